// File: rtl/ironhorse_hs_pkg.sv
// Shared types and defaults for the Iron Horse hiscore RAM arbitration.
// The state encoding is shared so benches and neighbours can decode it.
package ironhorse_hs_pkg;

    localparam int HS_AW         = 12;
    localparam int HS_DW         = 8;
    localparam int HS_SETTLE_DEF = 2;

    typedef enum logic [1:0] {
        CPU_OWN = 2'd0,
        SETTLE  = 2'd1,
        HS_OWN  = 2'd2,
        RELEASE = 2'd3
    } hs_state_t;

endpackage

// File: rtl/hs_wram_spram.sv
// Single-port synchronous work RAM with a one-cycle registered read.
// Write-first: on a write, the read port returns the new data.
module hs_wram_spram
    import ironhorse_hs_pkg::*;
#(
    parameter int AW = HS_AW,
    parameter int DW = HS_DW
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] addr_i,
    input  logic [DW-1:0] din_i,
    output logic [DW-1:0] dout_o
);

    logic [DW-1:0] mem_q [0:(1<<AW)-1];
    logic [DW-1:0] dout_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= din_i;
            dout_q        <= din_i;
        end else begin
            dout_q        <= mem_q[addr_i];
        end
    end

    assign dout_o = dout_q;

endmodule

// File: rtl/hiscore_ram_responder.sv
// Arbitrates the game work RAM between the CPU and the hiscore engine.
// The hiscore side only gets the port after pause_ack and intent hold steadily.
module hiscore_ram_responder
    import ironhorse_hs_pkg::*;
#(
    parameter int AW     = HS_AW,
    parameter int DW     = HS_DW,
    parameter int SETTLE = HS_SETTLE_DEF
) (
    input  logic          clk_49m,
    input  logic          reset,
    input  logic          cpu_cen,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_din,
    input  logic          cpu_we,
    output logic [DW-1:0] cpu_dout,
    input  logic          pause_ack,
    input  logic [AW-1:0] hs_address,
    input  logic [DW-1:0] hs_data_in,
    input  logic          hs_write_enable,
    input  logic          hs_access_read,
    input  logic          hs_access_write,
    output logic [DW-1:0] hs_data_out,
    output logic          hs_owner,
    output logic          cpu_blocked
);

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE - 1);

    hs_state_t     state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [DW-1:0] cpu_dout_q, cpu_dout_d;
    logic [DW-1:0] hs_data_out_q, hs_data_out_d;
    logic          hs_owner_q, hs_owner_d;
    logic          cpu_blocked_q, cpu_blocked_d;

    logic          intent;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din;
    logic [DW-1:0] ram_q;

    assign intent = hs_access_read | hs_access_write;

    // Exactly one source drives the RAM port; outside HS_OWN the CPU address
    // keeps the read pipeline primed for the CPU's return.
    always_comb begin
        ram_addr = cpu_addr;
        ram_din  = cpu_din;
        ram_we   = 1'b0;
        case (state_q)
            CPU_OWN: ram_we = cpu_we & cpu_cen;
            HS_OWN: begin
                ram_addr = hs_address;
                ram_din  = hs_data_in;
                ram_we   = hs_write_enable & hs_access_write & pause_ack;
            end
            default: ram_we = 1'b0;
        endcase
    end

    hs_wram_spram #(
        .AW (AW),
        .DW (DW)
    ) u_wram (
        .clk_i  (clk_49m),
        .we_i   (ram_we),
        .addr_i (ram_addr),
        .din_i  (ram_din),
        .dout_o (ram_q)
    );

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        cpu_dout_d    = cpu_dout_q;
        hs_data_out_d = hs_data_out_q;
        case (state_q)
            CPU_OWN: begin
                cpu_dout_d = ram_q;
                if (intent && pause_ack) begin
                    state_d = ironhorse_hs_pkg::SETTLE;
                    cnt_d   = SETTLE_LOAD;
                end
            end
            ironhorse_hs_pkg::SETTLE: begin
                if (!intent || !pause_ack) begin
                    state_d = CPU_OWN;
                end else if (cnt_q == 4'd0) begin
                    state_d = HS_OWN;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            HS_OWN: begin
                hs_data_out_d = ram_q;
                if (!intent || !pause_ack) begin
                    state_d = RELEASE;
                end
            end
            RELEASE: state_d = CPU_OWN;
            default: state_d = CPU_OWN;
        endcase
        hs_owner_d    = (state_d == HS_OWN);
        cpu_blocked_d = (state_d != CPU_OWN);
    end

    always_ff @(posedge clk_49m or negedge reset) begin
        if (!reset) begin
            state_q       <= CPU_OWN;
            cnt_q         <= 4'd0;
            cpu_dout_q    <= '0;
            hs_data_out_q <= '0;
            hs_owner_q    <= 1'b0;
            cpu_blocked_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            cpu_dout_q    <= cpu_dout_d;
            hs_data_out_q <= hs_data_out_d;
            hs_owner_q    <= hs_owner_d;
            cpu_blocked_q <= cpu_blocked_d;
        end
    end

    assign cpu_dout    = cpu_dout_q;
    assign hs_data_out = hs_data_out_q;
    assign hs_owner    = hs_owner_q;
    assign cpu_blocked = cpu_blocked_q;

endmodule

// File: tb/tb_hiscore_ram_responder.sv
// Directed bench for hiscore_ram_responder: CPU path, handover, blocking,
// aborts and asynchronous reset, with hand-computed expectations.
module tb_hiscore_ram_responder;

    logic        clk_49m = 1'b0;
    logic        reset;
    logic        cpu_cen;
    logic [11:0] cpu_addr;
    logic [7:0]  cpu_din;
    logic        cpu_we;
    logic [7:0]  cpu_dout;
    logic        pause_ack;
    logic [11:0] hs_address;
    logic [7:0]  hs_data_in;
    logic        hs_write_enable;
    logic        hs_access_read;
    logic        hs_access_write;
    logic [7:0]  hs_data_out;
    logic        hs_owner;
    logic        cpu_blocked;

    int checks = 0;
    int errors = 0;

    always #5 clk_49m = ~clk_49m;

    hiscore_ram_responder dut (
        .clk_49m         (clk_49m),
        .reset           (reset),
        .cpu_cen         (cpu_cen),
        .cpu_addr        (cpu_addr),
        .cpu_din         (cpu_din),
        .cpu_we          (cpu_we),
        .cpu_dout        (cpu_dout),
        .pause_ack       (pause_ack),
        .hs_address      (hs_address),
        .hs_data_in      (hs_data_in),
        .hs_write_enable (hs_write_enable),
        .hs_access_read  (hs_access_read),
        .hs_access_write (hs_access_write),
        .hs_data_out     (hs_data_out),
        .hs_owner        (hs_owner),
        .cpu_blocked     (cpu_blocked)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("check %-24s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk_49m);
        #1;
    endtask

    initial begin
        reset = 1'b0; cpu_cen = 1'b0; cpu_addr = '0; cpu_din = '0; cpu_we = 1'b0;
        pause_ack = 1'b0; hs_address = '0; hs_data_in = '0; hs_write_enable = 1'b0;
        hs_access_read = 1'b0; hs_access_write = 1'b0;
        step(2);
        check("rst_cpu_dout", cpu_dout, 8'h00);
        check("rst_hs_data_out", hs_data_out, 8'h00);
        check("rst_hs_owner", {7'd0, hs_owner}, 8'h00);
        check("rst_cpu_blocked", {7'd0, cpu_blocked}, 8'h00);
        reset = 1'b1;
        step(1);

        // CPU writes 0x5A@0x123 and 0x11@0x001, then reads 0x123 back
        cpu_cen = 1'b1; cpu_we = 1'b1; cpu_addr = 12'h123; cpu_din = 8'h5A;
        step(1);
        cpu_addr = 12'h001; cpu_din = 8'h11;
        step(1);
        cpu_we = 1'b0; cpu_addr = 12'h123;
        step(1);
        check("cpu_rd_lat_edge1", cpu_dout, 8'h11);
        step(1);
        check("cpu_rd_lat_edge2", cpu_dout, 8'h5A);
        check("cpu_path_hs_owner", {7'd0, hs_owner}, 8'h00);

        // Handover: hs_owner rises on the third edge
        pause_ack = 1'b1; hs_access_read = 1'b1; hs_address = 12'h123;
        step(1);
        check("settle_e1_owner", {7'd0, hs_owner}, 8'h00);
        check("settle_e1_blocked", {7'd0, cpu_blocked}, 8'h01);
        step(1);
        check("settle_e2_owner", {7'd0, hs_owner}, 8'h00);
        step(1);
        check("settle_e3_owner", {7'd0, hs_owner}, 8'h01);
        step(2);
        check("hs_rd_0x123", hs_data_out, 8'h5A);
        hs_address = 12'h001;
        step(1);
        check("hs_rd_lat_edge1", hs_data_out, 8'h5A);
        step(1);
        check("hs_rd_lat_edge2", hs_data_out, 8'h11);

        // Hiscore writes 0xC3@0x010 while the CPU tries 0xFF to the same address
        hs_access_write = 1'b1; hs_write_enable = 1'b1; hs_address = 12'h010; hs_data_in = 8'hC3;
        cpu_we = 1'b1; cpu_addr = 12'h010; cpu_din = 8'hFF;
        step(1);
        check("hs_wr_cpu_blocked", {7'd0, cpu_blocked}, 8'h01);
        check("hs_wr_cpu_dout_held", cpu_dout, 8'h5A);
        hs_write_enable = 1'b0; cpu_we = 1'b0;
        step(1);
        check("hs_rd_after_wr", hs_data_out, 8'hC3);

        // Drop intent: one RELEASE cycle, then CPU_OWN
        hs_access_read = 1'b0; hs_access_write = 1'b0;
        step(1);
        check("release_owner", {7'd0, hs_owner}, 8'h00);
        check("release_blocked", {7'd0, cpu_blocked}, 8'h01);
        step(1);
        check("cpu_own_blocked", {7'd0, cpu_blocked}, 8'h00);
        check("cpu_dout_held_pause", cpu_dout, 8'h5A);
        step(1);
        check("cpu_rd_0x010", cpu_dout, 8'hC3);

        // Abort during SETTLE
        hs_access_read = 1'b1;
        step(1);
        check("abort_settle_blk", {7'd0, cpu_blocked}, 8'h01);
        pause_ack = 1'b0;
        step(1);
        check("abort_settle_unblk", {7'd0, cpu_blocked}, 8'h00);
        check("abort_settle_owner", {7'd0, hs_owner}, 8'h00);
        step(2);
        check("abort_settle_owner2", {7'd0, hs_owner}, 8'h00);

        // Abort in HS_OWN with a write pending: write must be suppressed
        pause_ack = 1'b1; hs_access_write = 1'b1;
        step(3);
        check("abort_hs_owner_up", {7'd0, hs_owner}, 8'h01);
        hs_address = 12'h010; hs_data_in = 8'h77; hs_write_enable = 1'b1; pause_ack = 1'b0;
        step(1);
        check("abort_hs_release", {7'd0, hs_owner}, 8'h00);
        check("abort_hs_rel_blk", {7'd0, cpu_blocked}, 8'h01);
        hs_write_enable = 1'b0; hs_access_read = 1'b0; hs_access_write = 1'b0;
        step(2);
        check("abort_hs_no_write", cpu_dout, 8'hC3);

        // Asynchronous reset in the middle of HS_OWN
        pause_ack = 1'b1; hs_access_read = 1'b1;
        step(3);
        check("rst_mid_owner_up", {7'd0, hs_owner}, 8'h01);
        step(2);
        check("rst_mid_hs_data", hs_data_out, 8'hC3);
        #2;
        reset = 1'b0;
        #1;
        check("rst_mid_owner", {7'd0, hs_owner}, 8'h00);
        check("rst_mid_blocked", {7'd0, cpu_blocked}, 8'h00);
        check("rst_mid_cpu_dout", cpu_dout, 8'h00);
        check("rst_mid_hs_dout", hs_data_out, 8'h00);
        pause_ack = 1'b0; hs_access_read = 1'b0; cpu_addr = 12'h123;
        step(1);
        reset = 1'b1;
        step(2);
        check("ram_retained_0x123", cpu_dout, 8'h5A);
        cpu_addr = 12'h010;
        step(2);
        check("ram_retained_0x010", cpu_dout, 8'hC3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
